// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared types and elaboration-time helpers for the multi-port register file.
//   state_t   : clear-engine state (IDLE, CLEAR)
//   depth_of  : number of entries for a given address width
//   lane_lsb  : LSB position of lane k inside a packed multi-lane bus
package regfile_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int lane_lsb(input int k, input int lane_w);
        return k * lane_w;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
// One combinational read lane of the register file.
// Ports:
//   addr      in   read address of this lane
//   mem_data  in   array contents at addr
//   wr0/Rw0/busW0, wr1/Rw1/busW1  in  write ports, used for same-cycle bypass
//   busy      in   clear in progress; forces the lane to zero
//   data      out  read data
// Priority: busy zero, R0 zero, port 1 bypass, port 0 bypass, array.
module regfile_read_port #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int R0_ZERO = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] Rw0,
    input  logic [DATA_W-1:0] busW0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] Rw1,
    input  logic [DATA_W-1:0] busW1,
    input  logic              busy,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = mem_data;
        if (busy) begin
            data = '0;
        end else if ((R0_ZERO != 0) && (addr == '0)) begin
            data = '0;
        end else if (wr1 && (Rw1 == addr)) begin
            data = busW1;
        end else if (wr0 && (Rw0 == addr)) begin
            data = busW0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised register file: NREAD combinational read lanes with write
// bypass, two write ports (port 1 wins on an address clash), and a clear
// engine that zeroes one entry per cycle after reset or on request.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   wr0, Rw0, busW0   write port 0
//   wr1, Rw1, busW1   write port 1 (higher priority)
//   clr               clear request, honoured only when idle
//   Ra                packed read addresses, lane k at [k*ADDR_W +: ADDR_W]
//   busR              packed read data, lane k at [k*DATA_W +: DATA_W]
//   busy              clear in progress (registered)
//   collision         one-cycle pulse after both ports wrote the same address
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NREAD   = 2,
    parameter int R0_ZERO = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr0,
    input  logic [ADDR_W-1:0]         Rw0,
    input  logic [DATA_W-1:0]         busW0,
    input  logic                      wr1,
    input  logic [ADDR_W-1:0]         Rw1,
    input  logic [DATA_W-1:0]         busW1,
    input  logic                      clr,
    input  logic [NREAD*ADDR_W-1:0]   Ra,
    output logic [NREAD*DATA_W-1:0]   busR,
    output logic                      busy,
    output logic                      collision
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nx;
    logic              coll_nx;
    logic              we0;
    logic              we1;

    // busy is decoded straight from the state flop, so it is registered.
    assign busy = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            idx       <= '0;
            collision <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            collision <= coll_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nx = CLEAR;
                    idx_nx   = '0;
                end
            end
            CLEAR: begin
                if (idx == '1) begin
                    state_nx = IDLE;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            default: begin
                state_nx = CLEAR;
                idx_nx   = '0;
            end
        endcase
    end

    // A clash is flagged even when the shared address is the hardwired entry 0.
    assign coll_nx = (state == IDLE) && wr0 && wr1 && (Rw0 == Rw1);

    assign we1 = (state == IDLE) && wr1 && !((R0_ZERO != 0) && (Rw1 == '0));
    assign we0 = (state == IDLE) && wr0 && !((R0_ZERO != 0) && (Rw0 == '0))
                 && !(wr1 && (Rw1 == Rw0));

    // Array contents are deliberately not reset; the clear engine zeroes them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[idx] <= '0;
            end else begin
                if (we0) begin
                    mem[Rw0] <= busW0;
                end
                if (we1) begin
                    mem[Rw1] <= busW1;
                end
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [ADDR_W-1:0] lane_addr;
        assign lane_addr = Ra[lane_lsb(k, ADDR_W) +: ADDR_W];

        regfile_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .R0_ZERO (R0_ZERO)
        ) u_read_port (
            .addr     (lane_addr),
            .mem_data (mem[lane_addr]),
            .wr0      (wr0),
            .Rw0      (Rw0),
            .busW0    (busW0),
            .wr1      (wr1),
            .Rw1      (Rw1),
            .busW1    (busW1),
            .busy     (busy),
            .data     (busR[lane_lsb(k, DATA_W) +: DATA_W])
        );
    end

endmodule
